// File: rtl/e203_rst_pkg.sv
// e203 reset sequencer: shared state encoding, cause bit indices
// and counter sizing helper.
package e203_rst_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } rst_state_e;

  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_EXT  = 1;
  localparam int CAUSE_LOCK = 2;
  localparam int CAUSE_SW   = 3;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/e203_rst_seq_if.sv
// e203 reset sequencer bundle: raw reset sources in, sequenced
// resets out. Cause port pair exists only with E203_RST_CAUSE_EN.
interface e203_rst_seq_if #(
  parameter int NUM_RST = 4
);
  logic               erst_n;
  logic               pll_lock;
  logic               sw_rst_req;
  logic [NUM_RST-1:0] rst_n_out;
  logic               rst_done;
`ifdef E203_RST_CAUSE_EN
  logic [3:0]         rst_cause;
  logic               cause_clr;

  modport master (
    input  erst_n, pll_lock, sw_rst_req, cause_clr,
    output rst_n_out, rst_done, rst_cause
  );
  modport slave (
    output erst_n, pll_lock, sw_rst_req, cause_clr,
    input  rst_n_out, rst_done, rst_cause
  );
`else
  modport master (
    input  erst_n, pll_lock, sw_rst_req,
    output rst_n_out, rst_done
  );
  modport slave (
    output erst_n, pll_lock, sw_rst_req,
    input  rst_n_out, rst_done
  );
`endif
endinterface

// File: rtl/e203_rst_filt.sv
// Synchroniser chain plus glitch filter: the output only follows
// the synchronised input after FILT_CYCLES consecutive mismatches.
module e203_rst_filt
  import e203_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk_in,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int CW = cnt_width(FILT_CYCLES, 1, 1);
  localparam logic [CW-1:0] LAST = CW'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   din_s;

  assign din_s = sync[SYNC_STAGES-1];

  // two-flop style synchroniser, clears to "asserted"
  always_ff @(posedge clk_in) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], din};
  end

  // any matching sample restarts the mismatch run
  always_ff @(posedge clk_in) begin
    if (reset) begin
      dout <= 1'b0;
      cnt  <= '0;
    end else if (din_s == dout) begin
      cnt  <= '0;
    end else if (cnt == LAST) begin
      dout <= din_s;
      cnt  <= '0;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/e203_rst_seq.sv
// e203 reset sequencer: staggered release of NUM_RST resets after
// pad reset and PLL lock settle. Option: E203_RST_CAUSE_EN.
module e203_rst_seq
  import e203_rst_pkg::*;
#(
  parameter int NUM_RST     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int LOCK_STABLE = 32,
  parameter int STAGE_DLY   = 16
) (
  input logic            clk_in,
  input logic            reset,
  e203_rst_seq_if.master bus
);
  localparam int CW =
    cnt_width(LOCK_STABLE, STAGE_DLY, FILT_CYCLES);
  localparam int IW =
    (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  rst_state_e             state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic [IW-1:0]          idx, idx_nx;
  logic [NUM_RST-1:0]     rst_q, rst_nx;
  logic                   done_q, done_nx;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   lock_s;
  logic                   erst_f;
  logic                   abort;

  e203_rst_filt #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_CYCLES(FILT_CYCLES)
  ) u_erst_filt (
    .clk_in(clk_in),
    .reset (reset),
    .din   (bus.erst_n),
    .dout  (erst_f)
  );

  assign lock_s = lock_sync[SYNC_STAGES-1];
  assign abort  = !erst_f || !lock_s || bus.sw_rst_req;

  // lock only needs synchronising; its stability is counted later
  always_ff @(posedge clk_in) begin
    if (reset) lock_sync <= '0;
    else       lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.pll_lock};
  end

  // sequencer registers; outputs come straight from flops
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state  <= HOLD;
      cnt    <= '0;
      idx    <= '0;
      rst_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      rst_q  <= rst_nx;
      done_q <= done_nx;
    end
  end

  // next state; abort beats a same-cycle stage release
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    rst_nx   = rst_q;
    done_nx  = done_q;
    unique case (state)
      HOLD: begin
        rst_nx  = '0;
        done_nx = 1'b0;
        cnt_nx  = '0;
        idx_nx  = '0;
        if (erst_f && !bus.sw_rst_req) state_nx = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (!erst_f || bus.sw_rst_req) begin
          state_nx = HOLD;
          cnt_nx   = '0;
        end else if (!lock_s) begin
          cnt_nx = '0;
        end else if (cnt == CW'(LOCK_STABLE - 1)) begin
          state_nx = RELEASE;
          cnt_nx   = '0;
          idx_nx   = '0;
        end else if (cnt != '1) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (abort) begin
          state_nx = HOLD;
          cnt_nx   = '0;
          rst_nx   = '0;
          done_nx  = 1'b0;
        end else if (cnt == CW'(STAGE_DLY - 1)) begin
          rst_nx[idx] = 1'b1;
          cnt_nx      = '0;
          if (idx == IW'(NUM_RST - 1)) begin
            state_nx = RUN;
            done_nx  = 1'b1;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end else if (cnt != '1) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = HOLD;
          cnt_nx   = '0;
          rst_nx   = '0;
          done_nx  = 1'b0;
        end
      end
    endcase
  end

  assign bus.rst_n_out = rst_q;
  assign bus.rst_done  = done_q;

`ifdef E203_RST_CAUSE_EN
  logic [3:0] cause_q;
  logic [3:0] cap;

  // sources active on the edge that enters HOLD
  always_comb begin
    cap = '0;
    if (state != HOLD && state_nx == HOLD) begin
      cap[CAUSE_SW]   = bus.sw_rst_req;
      cap[CAUSE_EXT]  = !erst_f;
      cap[CAUSE_LOCK] = !lock_s &&
                        (state == RELEASE || state == RUN);
    end
  end

  // sticky causes; a capture survives a same-cycle clear
  always_ff @(posedge clk_in) begin
    if (reset)              cause_q <= 4'(1 << CAUSE_POR);
    else if (bus.cause_clr) cause_q <= cap;
    else                    cause_q <= cause_q | cap;
  end

  assign bus.rst_cause = cause_q;
`endif

endmodule

// File: tb/tb_e203_rst_seq.sv
// Directed bench for e203_rst_seq: checkpoint table over a long
// scripted run, then hand sequences for lock chatter and causes.
module tb_e203_rst_seq;

  typedef struct {
    int         cyc;
    logic       erst_n;
    logic       pll_lock;
    logic       sw;
    logic [3:0] rst_n;
    logic       done;
  } vec_t;

  logic clk;
  logic reset;
  int   cyc;
  int   nvec;
  int   nerr;
  vec_t vt[$];

  e203_rst_seq_if #(.NUM_RST(4)) bus ();

  e203_rst_seq #(
    .NUM_RST    (4),
    .SYNC_STAGES(2),
    .FILT_CYCLES(4),
    .LOCK_STABLE(32),
    .STAGE_DLY  (16)
  ) dut (
    .clk_in(clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic add(input int c, input logic e,
                     input logic l, input logic s,
                     input logic [3:0] r, input logic d);
    vt.push_back('{c, e, l, s, r, d});
  endtask

  task automatic wait_done(input int lim, output logic ok);
    int n;
    n = 0;
    while (bus.rst_done !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    ok = (bus.rst_done === 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    logic ok;
    logic lk;
    int   t0;
    nvec = 0;
    nerr = 0;
    cyc  = 0;
    bus.erst_n     = 1'b1;
    bus.pll_lock   = 1'b1;
    bus.sw_rst_req = 1'b0;
`ifdef E203_RST_CAUSE_EN
    bus.cause_clr  = 1'b0;
`endif

    // power-up release
    add(  0, 1, 1, 0, 4'b0000, 0);
    add(  1, 1, 1, 0, 4'b0000, 0);
    add( 54, 1, 1, 0, 4'b0000, 0);
    add( 55, 1, 1, 0, 4'b0001, 0);
    add( 70, 1, 1, 0, 4'b0001, 0);
    add( 71, 1, 1, 0, 4'b0011, 0);
    add( 86, 1, 1, 0, 4'b0011, 0);
    add( 87, 1, 1, 0, 4'b0111, 0);
    add(102, 1, 1, 0, 4'b0111, 0);
    add(103, 1, 1, 0, 4'b1111, 1);
    add(150, 1, 1, 0, 4'b1111, 1);
    // one-cycle lock drop in RUN
    add(200, 1, 0, 0, 4'b1111, 1);
    add(201, 1, 1, 0, 4'b1111, 1);
    add(202, 1, 1, 0, 4'b1111, 1);
    add(203, 1, 1, 0, 4'b0000, 0);
    add(204, 1, 1, 0, 4'b0000, 0);
    add(251, 1, 1, 0, 4'b0000, 0);
    add(252, 1, 1, 0, 4'b0001, 0);
    add(268, 1, 1, 0, 4'b0011, 0);
    add(284, 1, 1, 0, 4'b0111, 0);
    add(299, 1, 1, 0, 4'b0111, 0);
    add(300, 1, 1, 0, 4'b1111, 1);
    // 3-cycle pad glitch is filtered
    add(350, 0, 1, 0, 4'b1111, 1);
    add(353, 1, 1, 0, 4'b1111, 1);
    add(360, 1, 1, 0, 4'b1111, 1);
    // 4-cycle pad reset takes effect
    add(400, 0, 1, 0, 4'b1111, 1);
    add(404, 1, 1, 0, 4'b1111, 1);
    add(406, 1, 1, 0, 4'b1111, 1);
    add(407, 1, 1, 0, 4'b0000, 0);
    add(458, 1, 1, 0, 4'b0000, 0);
    add(459, 1, 1, 0, 4'b0001, 0);
    add(506, 1, 1, 0, 4'b0111, 0);
    add(507, 1, 1, 0, 4'b1111, 1);
    // software request in RUN
    add(550, 1, 1, 1, 4'b1111, 1);
    add(551, 1, 1, 0, 4'b0000, 0);
    add(599, 1, 1, 0, 4'b0000, 0);
    add(600, 1, 1, 0, 4'b0001, 0);
    add(616, 1, 1, 0, 4'b0011, 0);
    // software request on bit 2 release edge
    add(631, 1, 1, 1, 4'b0011, 0);
    add(632, 1, 1, 0, 4'b0000, 0);
    add(633, 1, 1, 0, 4'b0000, 0);
    add(680, 1, 1, 0, 4'b0000, 0);
    add(681, 1, 1, 0, 4'b0001, 0);

    do_reset();

    for (int i = 0; i < vt.size(); i++) begin
      while (cyc < vt[i].cyc) tick();
      chk($sformatf("vec%0d", i),
          32'({bus.rst_n_out, bus.rst_done}),
          32'({vt[i].rst_n, vt[i].done}));
      bus.erst_n     = vt[i].erst_n;
      bus.pll_lock   = vt[i].pll_lock;
      bus.sw_rst_req = vt[i].sw;
    end

    // lock chatter in WAIT_LOCK never releases
    bus.sw_rst_req = 1'b1;
    tick();
    bus.sw_rst_req = 1'b0;
    lk = 1'b1;
    for (int k = 0; k < 10; k++) begin
      lk = ~lk;
      bus.pll_lock = lk;
      for (int j = 0; j < 20; j++) begin
        tick();
        chk("chatter", 32'({bus.rst_n_out, bus.rst_done}), 32'h0);
      end
    end
    bus.pll_lock = 1'b1;
    wait_done(200, ok);
    chk("chatter_recover", 32'(ok), 32'd1);
    chk("chatter_outs", 32'(bus.rst_n_out), 32'hf);

    // reset mid-run, then exact release latency again
    do_reset();
    chk("rst_outs", 32'({bus.rst_n_out, bus.rst_done}), 32'h0);
`ifdef E203_RST_CAUSE_EN
    chk("cause_por", 32'(bus.rst_cause), 32'b0001);
`endif
    wait_done(200, ok);
    chk("redone", 32'(ok), 32'd1);
    chk("redone_cyc", 32'(cyc), 32'd103);

`ifdef E203_RST_CAUSE_EN
    bus.sw_rst_req = 1'b1;
    tick();
    bus.sw_rst_req = 1'b0;
    chk("cause_sw", 32'(bus.rst_cause), 32'b1001);
    wait_done(200, ok);
    chk("cause_run", 32'(ok), 32'd1);
    bus.cause_clr = 1'b1;
    tick();
    bus.cause_clr = 1'b0;
    chk("cause_clr", 32'(bus.rst_cause), 32'b0000);
    bus.pll_lock = 1'b0;
    tick();
    bus.pll_lock = 1'b1;
    tick();
    bus.cause_clr = 1'b1;
    tick();
    bus.cause_clr = 1'b0;
    chk("cause_lock", 32'(bus.rst_cause), 32'b0100);
    chk("cause_outs", 32'(bus.rst_n_out), 32'h0);
`endif

    t0 = cyc;
    tick();
    chk("end_cyc", 32'(cyc), 32'(t0 + 1));
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
